// File: rtl/flowstate_sendmau_wb_pkg.sv
// Shared constants for the flowstate send-side MAU stage: PHV container
// geometry, data-packet flag location and match-select encodings.
package flowstate_sendmau_wb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  localparam int unsigned DEF_PHV_WIDTH       = 592;
  localparam int unsigned DEF_PHV_B_COUNT     = 10;
  localparam int unsigned DEF_PHV_H_COUNT     = 2;
  localparam int unsigned DEF_PHV_W_COUNT     = 15;
  localparam int unsigned DEF_FLOWSTATE_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH      = 10;

  // Protocol byte container and the bit inside it that marks a data packet
  localparam int unsigned PROTO_BYTE_IDX = 0;
  localparam int unsigned DATA_PKT_BIT   = 2;

  localparam int unsigned HIST_DEPTH = 3;

  // Upstream tracker result: no match, or match at history depth 0/1/2
  typedef enum logic [1:0] {
    MATCH_NONE  = 2'b00,
    MATCH_HIST0 = 2'b01,
    MATCH_HIST1 = 2'b10,
    MATCH_HIST2 = 2'b11
  } match_sel_e;

  // PHV packs byte containers from bit 0, then halfwords, then words
  function automatic int unsigned word_lsb(int unsigned b_count,
                                           int unsigned h_count,
                                           int unsigned w_idx);
    return b_count * BYTE_W + h_count * HALF_W + w_idx * WORD_W;
  endfunction

endpackage

// File: rtl/flowstate_sendmau_wb_if.sv
// PHV in/out streams, flowstate table write port and update broadcast.
interface flowstate_sendmau_wb_if #(
  parameter int unsigned PHV_WIDTH       = flowstate_sendmau_wb_pkg::DEF_PHV_WIDTH,
  parameter int unsigned FLOWSTATE_WIDTH = flowstate_sendmau_wb_pkg::DEF_FLOWSTATE_WIDTH,
  parameter int unsigned ADDR_WIDTH      = flowstate_sendmau_wb_pkg::DEF_ADDR_WIDTH
);

  logic [PHV_WIDTH-1:0]       s_phv_info;
  logic [1:0]                 s_phv_match_sel;
  logic                       s_phv_mat_hit;
  logic [FLOWSTATE_WIDTH-1:0] s_phv_mat_value;
  logic [ADDR_WIDTH-1:0]      s_phv_mat_addr;
  logic                       s_phv_valid;
  logic                       s_phv_ready;

  logic [PHV_WIDTH-1:0]       m_phv_info;
  logic                       m_phv_valid;
  logic                       m_phv_ready;

  logic [ADDR_WIDTH-1:0]      m_wr_addr;
  logic [FLOWSTATE_WIDTH-1:0] m_wr_data;
  logic                       m_wr_valid;
  logic                       m_wr_ready;

  logic [FLOWSTATE_WIDTH:0]   bcd_flowstate_out;
  logic [ADDR_WIDTH-1:0]      bcd_addr_out;
  logic                       bcd_valid_out;

  // Environment side: drives the PHV source and the downstream sinks
  modport master (
    output s_phv_info, s_phv_match_sel, s_phv_mat_hit, s_phv_mat_value,
           s_phv_mat_addr, s_phv_valid,
    input  s_phv_ready,
    input  m_phv_info, m_phv_valid,
    output m_phv_ready,
    input  m_wr_addr, m_wr_data, m_wr_valid,
    output m_wr_ready,
    input  bcd_flowstate_out, bcd_addr_out, bcd_valid_out
  );

  // Stage side
  modport slave (
    input  s_phv_info, s_phv_match_sel, s_phv_mat_hit, s_phv_mat_value,
           s_phv_mat_addr, s_phv_valid,
    output s_phv_ready,
    output m_phv_info, m_phv_valid,
    input  m_phv_ready,
    output m_wr_addr, m_wr_data, m_wr_valid,
    input  m_wr_ready,
    output bcd_flowstate_out, bcd_addr_out, bcd_valid_out
  );

endinterface

// File: rtl/flowstate_sendmau_wb_hist3.sv
// Three-deep history of recent accepts so a PHV that hits the same flow as
// one still in flight to the table picks up the freshest flowstate.
module flowstate_hist3
  import flowstate_sendmau_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned FLOWSTATE_WIDTH = DEF_FLOWSTATE_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_i,
  input  logic                       ent_valid_i,
  input  logic [ADDR_WIDTH-1:0]      ent_addr_i,
  input  logic [FLOWSTATE_WIDTH-1:0] ent_value_i,
  input  match_sel_e                 sel_i,
  output logic                       rd_hit_c,
  output logic [FLOWSTATE_WIDTH-1:0] rd_value_c
);

  typedef struct packed {
    logic                       valid;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [FLOWSTATE_WIDTH-1:0] value;
  } hist_entry_t;

  hist_entry_t hist_q [HIST_DEPTH];
  hist_entry_t hist_d [HIST_DEPTH];

  // Shift one slot per accept; the new entry lands at depth 0
  always_comb begin
    for (int i = 0; i < int'(HIST_DEPTH); i++) begin
      hist_d[i] = hist_q[i];
    end
    if (shift_i) begin
      for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
        hist_d[i] = hist_q[i-1];
      end
      hist_d[0].valid = ent_valid_i;
      hist_d[0].addr  = ent_addr_i;
      hist_d[0].value = ent_value_i;
    end
  end

  // History register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(HIST_DEPTH); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(HIST_DEPTH); i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // Select read: the upstream tracker names the depth, we report its state
  always_comb begin
    rd_hit_c   = 1'b0;
    rd_value_c = '0;
    case (sel_i)
      MATCH_HIST0: begin
        rd_hit_c   = hist_q[0].valid;
        rd_value_c = hist_q[0].value;
      end
      MATCH_HIST1: begin
        rd_hit_c   = hist_q[1].valid;
        rd_value_c = hist_q[1].value;
      end
      MATCH_HIST2: begin
        rd_hit_c   = hist_q[2].valid;
        rd_value_c = hist_q[2].value;
      end
      default: begin
        rd_hit_c   = 1'b0;
        rd_value_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/flowstate_sendmau_wb.sv
// Send-side flowstate stage: stamps the current send sequence into a PHV
// word, writes the incremented flowstate back to the table and broadcasts it.
module flowstate_sendmau_wb
  import flowstate_sendmau_wb_pkg::*;
#(
  parameter int unsigned PHV_WIDTH       = DEF_PHV_WIDTH,
  parameter int unsigned PHV_B_COUNT     = DEF_PHV_B_COUNT,
  parameter int unsigned PHV_H_COUNT     = DEF_PHV_H_COUNT,
  parameter int unsigned PHV_W_COUNT     = DEF_PHV_W_COUNT,
  parameter int unsigned FLOWSTATE_WIDTH = DEF_FLOWSTATE_WIDTH,
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned SEQ_W_INDEX     = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  flowstate_sendmau_wb_if.slave bus
);

  localparam int unsigned SEQ_IDX  = (SEQ_W_INDEX < PHV_W_COUNT) ? SEQ_W_INDEX : 0;
  localparam int unsigned SEQ_LSB  = word_lsb(PHV_B_COUNT, PHV_H_COUNT, SEQ_IDX);
  localparam int unsigned DATA_BIT = PROTO_BYTE_IDX * BYTE_W + DATA_PKT_BIT;

  logic                       s_phv_ready_c;
  logic                       accept_c;
  logic                       update_c;
  logic                       hist_hit_c;
  logic [FLOWSTATE_WIDTH-1:0] hist_value_c;
  logic [FLOWSTATE_WIDTH-1:0] eff_value_c;
  logic [FLOWSTATE_WIDTH-1:0] new_fs_c;
  logic [PHV_WIDTH-1:0]       phv_fwd_c;

  logic                       m_phv_valid_q, m_phv_valid_d;
  logic [PHV_WIDTH-1:0]       m_phv_info_q,  m_phv_info_d;
  logic                       m_wr_valid_q,  m_wr_valid_d;
  logic [ADDR_WIDTH-1:0]      m_wr_addr_q,   m_wr_addr_d;
  logic [FLOWSTATE_WIDTH-1:0] m_wr_data_q,   m_wr_data_d;
  logic                       bcd_valid_q,   bcd_valid_d;
  logic [FLOWSTATE_WIDTH:0]   bcd_fs_q,      bcd_fs_d;
  logic [ADDR_WIDTH-1:0]      bcd_addr_q,    bcd_addr_d;

  // Flow history, shifted on every accept in lockstep with the tracker
  flowstate_hist3 #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .FLOWSTATE_WIDTH (FLOWSTATE_WIDTH)
  ) u_hist (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_i     (accept_c),
    .ent_valid_i (update_c),
    .ent_addr_i  (bus.s_phv_mat_addr),
    .ent_value_i (new_fs_c),
    .sel_i       (match_sel_e'(bus.s_phv_match_sel)),
    .rd_hit_c    (hist_hit_c),
    .rd_value_c  (hist_value_c)
  );

  // Handshake, effective flowstate and PHV rewrite
  always_comb begin
    s_phv_ready_c = rst_n
                  && (!m_phv_valid_q || bus.m_phv_ready)
                  && (!m_wr_valid_q  || bus.m_wr_ready);
    accept_c      = bus.s_phv_valid && s_phv_ready_c;
    update_c      = accept_c && bus.s_phv_mat_hit && bus.s_phv_info[DATA_BIT];
    eff_value_c   = hist_hit_c ? hist_value_c : bus.s_phv_mat_value;
    new_fs_c      = eff_value_c + FLOWSTATE_WIDTH'(1);
    phv_fwd_c     = bus.s_phv_info;
    if (update_c) begin
      phv_fwd_c[SEQ_LSB +: WORD_W] = WORD_W'(eff_value_c);
    end
  end

  // Next-state for the output PHV, table write and broadcast registers
  always_comb begin
    m_phv_valid_d = m_phv_valid_q;
    m_phv_info_d  = m_phv_info_q;
    m_wr_valid_d  = m_wr_valid_q;
    m_wr_addr_d   = m_wr_addr_q;
    m_wr_data_d   = m_wr_data_q;
    bcd_valid_d   = 1'b0;
    bcd_fs_d      = bcd_fs_q;
    bcd_addr_d    = bcd_addr_q;

    if (accept_c) begin
      m_phv_valid_d = 1'b1;
      m_phv_info_d  = phv_fwd_c;
    end else if (bus.m_phv_ready) begin
      m_phv_valid_d = 1'b0;
    end

    if (update_c) begin
      m_wr_valid_d = 1'b1;
      m_wr_addr_d  = bus.s_phv_mat_addr;
      m_wr_data_d  = new_fs_c;
      bcd_valid_d  = 1'b1;
      bcd_fs_d     = {1'b1, new_fs_c};
      bcd_addr_d   = bus.s_phv_mat_addr;
    end else if (bus.m_wr_ready) begin
      m_wr_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phv_valid_q <= 1'b0;
      m_phv_info_q  <= '0;
      m_wr_valid_q  <= 1'b0;
      m_wr_addr_q   <= '0;
      m_wr_data_q   <= '0;
      bcd_valid_q   <= 1'b0;
      bcd_fs_q      <= '0;
      bcd_addr_q    <= '0;
    end else begin
      m_phv_valid_q <= m_phv_valid_d;
      m_phv_info_q  <= m_phv_info_d;
      m_wr_valid_q  <= m_wr_valid_d;
      m_wr_addr_q   <= m_wr_addr_d;
      m_wr_data_q   <= m_wr_data_d;
      bcd_valid_q   <= bcd_valid_d;
      bcd_fs_q      <= bcd_fs_d;
      bcd_addr_q    <= bcd_addr_d;
    end
  end

  assign bus.s_phv_ready       = s_phv_ready_c;
  assign bus.m_phv_valid       = m_phv_valid_q;
  assign bus.m_phv_info        = m_phv_info_q;
  assign bus.m_wr_valid        = m_wr_valid_q;
  assign bus.m_wr_addr         = m_wr_addr_q;
  assign bus.m_wr_data         = m_wr_data_q;
  assign bus.bcd_valid_out     = bcd_valid_q;
  assign bus.bcd_flowstate_out = bcd_fs_q;
  assign bus.bcd_addr_out      = bcd_addr_q;

endmodule

// File: tb/tb_flowstate_sendmau_wb.sv
// Bench for flowstate_sendmau_wb: directed scenarios plus random traffic,
// all checked against a transaction-level model of the stage.
module tb_flowstate_sendmau_wb;

  localparam int unsigned PW      = 592;
  localparam int unsigned FW      = 32;
  localparam int unsigned AW      = 10;
  localparam int unsigned SEQ_LSB = 10 * 8 + 2 * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flowstate_sendmau_wb_if bus ();

  flowstate_sendmau_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [FW-1:0] val;
  } hent_t;

  // Reference model state
  hent_t         hist [3];
  logic          out_v;
  logic [PW-1:0] out_info;
  logic          wr_v;
  logic [AW-1:0] wr_a;
  logic [FW-1:0] wr_d;
  logic          bcd_v;
  logic [FW:0]   bcd_fs;
  logic [AW-1:0] bcd_a;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, '0, '0};
    out_v    = 1'b0;
    out_info = '0;
    wr_v     = 1'b0;
    wr_a     = '0;
    wr_d     = '0;
    bcd_v    = 1'b0;
    bcd_fs   = '0;
    bcd_a    = '0;
  endtask

  task automatic check_outputs();
    check("m_phv_valid", bus.m_phv_valid, out_v);
    if (out_v) check("m_phv_info", bus.m_phv_info, out_info);
    check("m_wr_valid", bus.m_wr_valid, wr_v);
    check("m_wr_addr", bus.m_wr_addr, wr_a);
    check("m_wr_data", bus.m_wr_data, wr_d);
    check("bcd_valid", bus.bcd_valid_out, bcd_v);
    check("bcd_flowstate", bus.bcd_flowstate_out, bcd_fs);
    check("bcd_addr", bus.bcd_addr_out, bcd_a);
  endtask

  // One cycle: drive at negedge, check ready, model the edge, check outputs
  task automatic step(input logic v, input logic [1:0] sel, input logic hit,
                      input logic [FW-1:0] val, input logic [AW-1:0] addr,
                      input logic dpkt, input logic mrdy, input logic wrdy);
    logic [607:0]  raw;
    logic [PW-1:0] info;
    logic          rdy;
    logic          upd;
    logic [FW-1:0] eff;
    logic [FW-1:0] nf;
    int            k;
    for (int i = 0; i < 19; i++) raw[i*32 +: 32] = $urandom();
    info    = raw[PW-1:0];
    info[2] = dpkt;
    bus.s_phv_info      = info;
    bus.s_phv_match_sel = sel;
    bus.s_phv_mat_hit   = hit;
    bus.s_phv_mat_value = val;
    bus.s_phv_mat_addr  = addr;
    bus.s_phv_valid     = v;
    bus.m_phv_ready     = mrdy;
    bus.m_wr_ready      = wrdy;
    rdy = rst_n && (!out_v || mrdy) && (!wr_v || wrdy);
    #1;
    check("s_phv_ready", bus.s_phv_ready, rdy);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (out_v && mrdy) out_v = 1'b0;
      if (wr_v && wrdy) wr_v = 1'b0;
      bcd_v = 1'b0;
      if (v && rdy) begin
        upd = hit && dpkt;
        eff = val;
        k   = int'(sel) - 1;
        if (sel != 2'b00 && hist[k].v) eff = hist[k].val;
        nf = eff + 1;
        out_info = info;
        if (upd) out_info[SEQ_LSB +: FW] = eff;
        out_v = 1'b1;
        if (upd) begin
          wr_v   = 1'b1;
          wr_a   = addr;
          wr_d   = nf;
          bcd_v  = 1'b1;
          bcd_fs = {1'b1, nf};
          bcd_a  = addr;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{upd, addr, nf};
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    idle();
    idle();
    rst_n = 1'b1;
    idle();

    // Single hit, no history
    step(1'b1, 2'b00, 1'b1, 32'h10, 10'd5, 1'b1, 1'b1, 1'b1);
    check("basic_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'h10);
    check("basic_wr_data", bus.m_wr_data, 32'h11);
    check("basic_bcd", bus.bcd_valid_out, 1'b1);
    idle();

    // Back-to-back on the same flow, second forwards from depth 0
    step(1'b1, 2'b00, 1'b1, 32'h10, 10'd5, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'b01, 1'b1, 32'h10, 10'd5, 1'b1, 1'b1, 1'b1);
    check("b2b_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'h11);
    check("b2b_wr_data", bus.m_wr_data, 32'h12);

    // Flows 7, 8, 7 with the third forwarding from depth 1
    step(1'b1, 2'b00, 1'b1, 32'h20, 10'd7, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'b00, 1'b1, 32'h30, 10'd8, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'b10, 1'b1, 32'h20, 10'd7, 1'b1, 1'b1, 1'b1);
    check("depth1_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'h21);
    check("depth1_wr_data", bus.m_wr_data, 32'h22);

    // Non-data accepts fill history with invalid entries; depth 2 falls back
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b1, 32'h1, 10'd1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b11, 1'b1, 32'h55, 10'd9, 1'b1, 1'b1, 1'b1);
    check("invalid_hist_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'h55);

    // Flowstate wrap
    step(1'b1, 2'b00, 1'b1, 32'hFFFF_FFFF, 10'd3, 1'b1, 1'b1, 1'b1);
    check("wrap_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'hFFFF_FFFF);
    check("wrap_wr_data", bus.m_wr_data, 32'h0);
    check("wrap_bcd", bus.bcd_flowstate_out, 33'h1_0000_0000);
    idle();

    // Table write stall backpressures input and freezes history
    step(1'b1, 2'b00, 1'b1, 32'h70, 10'd4, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b1, 32'h99, 10'd4, 1'b1, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 32'h99, 10'd4, 1'b1, 1'b1, 1'b1);
    check("stall_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'h71);
    check("stall_wr_data", bus.m_wr_data, 32'h72);

    // Miss and non-data passthrough
    step(1'b1, 2'b00, 1'b0, 32'h5, 10'd6, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'b00, 1'b1, 32'h5, 10'd6, 1'b0, 1'b1, 1'b1);
    check("passthru_no_wr", bus.m_wr_valid, 1'b0);

    // Random traffic with random backpressure
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 4) != 0, 2'($urandom), ($urandom % 4) != 0,
           (($urandom % 8) == 0) ? 32'hFFFF_FFFF : 32'($urandom % 64),
           10'($urandom % 4), ($urandom % 4) != 0,
           ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    // Reset with both the PHV and the table write pending
    idle();
    idle();
    step(1'b1, 2'b00, 1'b1, 32'h40, 10'd2, 1'b1, 1'b0, 1'b0);
    check("pre_rst_phv_valid", bus.m_phv_valid, 1'b1);
    check("pre_rst_wr_valid", bus.m_wr_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_phv_valid", bus.m_phv_valid, 1'b0);
    check("rst_wr_valid", bus.m_wr_valid, 1'b0);
    check("rst_bcd_valid", bus.bcd_valid_out, 1'b0);
    check("rst_s_ready", bus.s_phv_ready, 1'b0);
    check("rst_wr_data", bus.m_wr_data, 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    step(1'b1, 2'b01, 1'b1, 32'h40, 10'd2, 1'b1, 1'b1, 1'b1);
    check("post_rst_seq", bus.m_phv_info[SEQ_LSB +: FW], 32'h40);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
